// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the UART debug loader: command bytes, response codes
// and the controller state encoding.
package uart_dbg_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'

  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;

  localparam int WORD_IDX_W = 9;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_COUNT = 3'd1,
    LD_BYTE  = 3'd2,
    LD_WRITE = 3'd3,
    RESP     = 3'd4
  } loader_state_t;

endpackage

// File: rtl/uart_loader_ctrl_if.sv
// Signal bundle between the loader controller and its UART / instruction
// memory / CPU-control surroundings.
interface uart_loader_ctrl_if #(parameter int ADDR_W = 8);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              cpu_step;
  logic              busy;

  modport master (
    input  rx_data, rx_valid, tx_busy,
    output tx_start, tx_data, imem_we, imem_addr, imem_wdata,
           cpu_run, cpu_step, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_busy,
    input  tx_start, tx_data, imem_we, imem_addr, imem_wdata,
           cpu_run, cpu_step, busy
  );

endinterface

// File: rtl/uart_word_assembler.sv
// Packs four received bytes into a 32-bit word, little-endian (first byte
// lands in bits 7:0).
module uart_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        last_byte
);

  logic [1:0] byte_idx;

  // last_byte looks only at the index so the controller can decide on the
  // 4th byte without a combinational path back through byte_valid.
  assign last_byte = (byte_idx == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word     <= 32'h0;
      byte_idx <= 2'd0;
    end else if (clear) begin
      word     <= 32'h0;
      byte_idx <= 2'd0;
    end else if (byte_valid) begin
      case (byte_idx)
        2'd0:    word[7:0]   <= byte_data;
        2'd1:    word[15:8]  <= byte_data;
        2'd2:    word[23:16] <= byte_data;
        default: word[31:24] <= byte_data;
      endcase
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/uart_loader_ctrl.sv
// Byte-command controller behind a UART: loads instruction memory and
// starts, halts or single-steps the CPU, answering each command with ACK/NAK.
module uart_loader_ctrl
  import uart_dbg_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  uart_loader_ctrl_if.master bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  loader_state_t         state;
  loader_state_t         state_next;
  logic [WORD_IDX_W-1:0] word_idx;
  logic [WORD_IDX_W-1:0] word_count;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [7:0]            resp_byte;
  logic                  cpu_run_q;
  logic                  cpu_step_q;

  logic                  resp_load;
  logic [7:0]            resp_value;
  logic                  load_start;
  logic                  count_load;
  logic                  word_inc;
  logic                  run_set;
  logic                  run_clr;
  logic                  step_req;
  logic                  asm_valid;
  logic                  tx_start_c;
  logic                  tmo_hit;
  logic                  last_word;
  logic                  last_byte;
  logic [31:0]           asm_word;

  uart_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start),
    .byte_valid (asm_valid),
    .byte_data  (bus.rx_data),
    .word       (asm_word),
    .last_byte  (last_byte)
  );

  assign tmo_hit   = (tmo_cnt == TMO_LIMIT);
  assign last_word = ((word_idx + 9'd1) == word_count);

  assign bus.tx_start   = tx_start_c;
  assign bus.tx_data    = resp_byte;
  assign bus.imem_we    = (state == LD_WRITE);
  assign bus.imem_addr  = ADDR_W'(word_idx);
  assign bus.imem_wdata = asm_word;
  assign bus.cpu_run    = cpu_run_q;
  assign bus.cpu_step   = cpu_step_q;
  assign bus.busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command decode and load sequencing; anything not accepted in IDLE is
  // answered with NAK, and rx bytes in LD_WRITE/RESP are simply not looked at.
  always_comb begin
    state_next = state;
    resp_load  = 1'b0;
    resp_value = RESP_NAK;
    load_start = 1'b0;
    count_load = 1'b0;
    word_inc   = 1'b0;
    run_set    = 1'b0;
    run_clr    = 1'b0;
    step_req   = 1'b0;
    asm_valid  = 1'b0;
    tx_start_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          state_next = RESP;
          resp_load  = 1'b1;
          case (bus.rx_data)
            CMD_LOAD: begin
              if (!cpu_run_q) begin
                state_next = LD_COUNT;
                resp_load  = 1'b0;
                load_start = 1'b1;
              end
            end
            CMD_RUN: begin
              run_set    = 1'b1;
              resp_value = RESP_ACK;
            end
            CMD_HALT: begin
              run_clr    = 1'b1;
              resp_value = RESP_ACK;
            end
            CMD_STEP: begin
              if (!cpu_run_q) begin
                step_req   = 1'b1;
                resp_value = RESP_ACK;
              end
            end
            default: ;
          endcase
        end
      end
      LD_COUNT: begin
        if (bus.rx_valid) begin
          count_load = 1'b1;
          state_next = LD_BYTE;
        end else if (tmo_hit) begin
          resp_load  = 1'b1;
          state_next = RESP;
        end
      end
      LD_BYTE: begin
        if (bus.rx_valid) begin
          asm_valid = 1'b1;
          if (last_byte) begin
            state_next = LD_WRITE;
          end
        end else if (tmo_hit) begin
          resp_load  = 1'b1;
          state_next = RESP;
        end
      end
      LD_WRITE: begin
        word_inc = 1'b1;
        if (last_word) begin
          resp_load  = 1'b1;
          resp_value = RESP_ACK;
          state_next = RESP;
        end else begin
          state_next = LD_BYTE;
        end
      end
      RESP: begin
        if (!bus.tx_busy) begin
          tx_start_c = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A count byte of 0 means a full 256-word image.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_run_q  <= 1'b0;
      cpu_step_q <= 1'b0;
      resp_byte  <= 8'h00;
      word_idx   <= '0;
      word_count <= '0;
      tmo_cnt    <= '0;
    end else begin
      cpu_step_q <= step_req;
      if (run_set) begin
        cpu_run_q <= 1'b1;
      end else if (run_clr) begin
        cpu_run_q <= 1'b0;
      end
      if (resp_load) begin
        resp_byte <= resp_value;
      end
      if (load_start) begin
        word_idx <= '0;
      end else if (word_inc) begin
        word_idx <= word_idx + 9'd1;
      end
      if (count_load) begin
        word_count <= (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
      end
      if (bus.rx_valid || load_start) begin
        tmo_cnt <= '0;
      end else if (state == LD_COUNT || state == LD_BYTE) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Directed self-checking bench for uart_loader_ctrl: load, run/halt/step
// commands, timeout abort, transmitter back-pressure and mid-load reset.
module tb_uart_loader_ctrl;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 200;

  logic clk;
  logic reset;

  int checks;
  int failures;

  logic [ADDR_W-1:0] we_addr_q[$];
  logic [31:0]       we_data_q[$];
  logic [7:0]        tx_q[$];
  int                step_cnt;

  uart_loader_ctrl_if #(.ADDR_W(ADDR_W)) ifc ();

  uart_loader_ctrl #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive recorder, sampled mid-way through the low clock phase.
  always @(negedge clk) begin
    #2;
    if (ifc.imem_we) begin
      we_addr_q.push_back(ifc.imem_addr);
      we_data_q.push_back(ifc.imem_wdata);
    end
    if (ifc.tx_start) tx_q.push_back(ifc.tx_data);
    if (ifc.cpu_step) step_cnt++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    @(negedge clk);
    ifc.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_tx(input int target, input int budget, output int cycles);
    cycles = 0;
    while (tx_q.size() < target && cycles < budget) begin
      @(negedge clk);
      #3;
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    checks += 8;
    if (ifc.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", ifc.busy); end
    if (ifc.tx_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_start got %b want 0", ifc.tx_start); end
    if (ifc.tx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_data got %h want 00", ifc.tx_data); end
    if (ifc.imem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_imem_we got %b want 0", ifc.imem_we); end
    if (ifc.imem_addr !== 8'h00) begin failures++; $display("[TB] FAIL reset_imem_addr got %h want 00", ifc.imem_addr); end
    if (ifc.imem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_imem_wdata got %h want 0", ifc.imem_wdata); end
    if (ifc.cpu_run !== 1'b0) begin failures++; $display("[TB] FAIL reset_cpu_run got %b want 0", ifc.cpu_run); end
    if (ifc.cpu_step !== 1'b0) begin failures++; $display("[TB] FAIL reset_cpu_step got %b want 0", ifc.cpu_step); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_word;
    int we0, tx0, cyc;
    we0 = we_addr_q.size();
    tx0 = tx_q.size();
    send_byte(8'h4C, 2);
    send_byte(8'h01, 2);
    send_byte(8'h78, 2);
    send_byte(8'h56, 2);
    send_byte(8'h34, 2);
    send_byte(8'h12, 0);
    wait_tx(tx0 + 1, 50, cyc);
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (we_addr_q.size() - we0 !== 1) begin
      failures++; $display("[TB] FAIL single_we_count got %0d want 1", we_addr_q.size() - we0);
    end else begin
      checks += 2;
      if (we_addr_q[we0] !== 8'h00) begin failures++; $display("[TB] FAIL single_addr got %h want 00", we_addr_q[we0]); end
      if (we_data_q[we0] !== 32'h12345678) begin failures++; $display("[TB] FAIL single_wdata got %h want 12345678", we_data_q[we0]); end
    end
    checks++;
    if (tx_q.size() - tx0 !== 1) begin
      failures++; $display("[TB] FAIL single_tx_count got %0d want 1", tx_q.size() - tx0);
    end else begin
      checks++;
      if (tx_q[tx0] !== 8'h06) begin failures++; $display("[TB] FAIL single_ack got %h want 06", tx_q[tx0]); end
    end
    checks++;
    if (ifc.busy !== 1'b0) begin failures++; $display("[TB] FAIL single_idle got busy=%b want 0", ifc.busy); end
  endtask

  task automatic test_full_load;
    int we0, tx0, cyc, bad_addr, bad_data;
    logic [31:0] exp_word;
    we0 = we_addr_q.size();
    tx0 = tx_q.size();
    send_byte(8'h4C, 2);
    send_byte(8'h00, 2);
    for (int i = 0; i < 1024; i++) send_byte(8'(i), 2);
    wait_tx(tx0 + 1, 50, cyc);
    repeat (5) @(negedge clk);
    #3;
    checks++;
    if (we_addr_q.size() - we0 !== 256) begin
      failures++; $display("[TB] FAIL full_we_count got %0d want 256", we_addr_q.size() - we0);
    end else begin
      bad_addr = 0;
      bad_data = 0;
      for (int w = 0; w < 256; w++) begin
        exp_word = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
        if (we_addr_q[we0+w] !== 8'(w)) bad_addr++;
        if (we_data_q[we0+w] !== exp_word) bad_data++;
      end
      checks += 4;
      if (bad_addr != 0) begin failures++; $display("[TB] FAIL full_addr_seq got %0d bad want 0 bad", bad_addr); end
      if (bad_data != 0) begin failures++; $display("[TB] FAIL full_data_seq got %0d bad want 0 bad", bad_data); end
      if (we_data_q[we0] !== 32'h03020100) begin failures++; $display("[TB] FAIL full_word0 got %h want 03020100", we_data_q[we0]); end
      if (we_data_q[we0+255] !== 32'hFFFEFDFC) begin failures++; $display("[TB] FAIL full_word255 got %h want fffefdfc", we_data_q[we0+255]); end
    end
    checks++;
    if (tx_q.size() - tx0 !== 1) begin
      failures++; $display("[TB] FAIL full_tx_count got %0d want 1", tx_q.size() - tx0);
    end else begin
      checks++;
      if (tx_q[tx0] !== 8'h06) begin failures++; $display("[TB] FAIL full_ack got %h want 06", tx_q[tx0]); end
    end
  endtask

  task automatic test_run_cmds;
    logic [7:0] cmds[4];
    logic [7:0] exp_resp[4];
    logic       exp_run[4];
    int we0, st0, tx0, cyc;
    cmds     = '{8'h52, 8'h53, 8'h4C, 8'h48};
    exp_resp = '{8'h06, 8'h15, 8'h15, 8'h06};
    exp_run  = '{1'b1, 1'b1, 1'b1, 1'b0};
    we0 = we_addr_q.size();
    st0 = step_cnt;
    for (int k = 0; k < 4; k++) begin
      tx0 = tx_q.size();
      send_byte(cmds[k], 0);
      wait_tx(tx0 + 1, 20, cyc);
      repeat (2) @(negedge clk);
      #3;
      checks += 3;
      if (tx_q.size() != tx0 + 1 || tx_q[tx0] !== exp_resp[k]) begin
        failures++;
        $display("[TB] FAIL cmd%0d_resp got %h (n=%0d) want %h", k, (tx_q.size() > tx0) ? tx_q[tx0] : 8'hxx, tx_q.size() - tx0, exp_resp[k]);
      end
      if (ifc.cpu_run !== exp_run[k]) begin failures++; $display("[TB] FAIL cmd%0d_cpu_run got %b want %b", k, ifc.cpu_run, exp_run[k]); end
      if (ifc.busy !== 1'b0) begin failures++; $display("[TB] FAIL cmd%0d_idle got busy=%b want 0", k, ifc.busy); end
    end
    checks += 2;
    if (step_cnt != st0) begin failures++; $display("[TB] FAIL cmds_no_step got %0d want 0", step_cnt - st0); end
    if (we_addr_q.size() != we0) begin failures++; $display("[TB] FAIL cmds_no_we got %0d want 0", we_addr_q.size() - we0); end
  endtask

  task automatic test_timeout;
    int we0, tx0, cyc;
    we0 = we_addr_q.size();
    tx0 = tx_q.size();
    send_byte(8'h4C, 2);
    send_byte(8'h02, 2);
    send_byte(8'h11, 2);
    send_byte(8'h22, 2);
    send_byte(8'h33, 2);
    send_byte(8'h44, 2);
    send_byte(8'h55, 2);
    wait_tx(tx0 + 1, TIMEOUT + 100, cyc);
    checks++;
    if (cyc < TIMEOUT - 10 || cyc > TIMEOUT + 10) begin
      failures++; $display("[TB] FAIL tmo_latency got %0d cycles want about %0d", cyc, TIMEOUT);
    end
    repeat (20) @(negedge clk);
    #3;
    checks++;
    if (we_addr_q.size() - we0 !== 1) begin
      failures++; $display("[TB] FAIL tmo_we_count got %0d want 1", we_addr_q.size() - we0);
    end else begin
      checks += 2;
      if (we_addr_q[we0] !== 8'h00) begin failures++; $display("[TB] FAIL tmo_addr got %h want 00", we_addr_q[we0]); end
      if (we_data_q[we0] !== 32'h44332211) begin failures++; $display("[TB] FAIL tmo_wdata got %h want 44332211", we_data_q[we0]); end
    end
    checks += 2;
    if (tx_q.size() != tx0 + 1 || tx_q[tx0] !== 8'h15) begin
      failures++; $display("[TB] FAIL tmo_nak got n=%0d want one 15", tx_q.size() - tx0);
    end
    if (ifc.busy !== 1'b0) begin failures++; $display("[TB] FAIL tmo_idle got busy=%b want 0", ifc.busy); end
  endtask

  task automatic test_tx_busy;
    int tx0, st0, cyc;
    tx0 = tx_q.size();
    st0 = step_cnt;
    @(negedge clk);
    ifc.tx_busy = 1'b1;
    send_byte(8'h53, 5);
    send_byte(8'h52, 0);
    repeat (40) @(negedge clk);
    #3;
    checks += 3;
    if (tx_q.size() != tx0) begin failures++; $display("[TB] FAIL busy_hold_tx got %0d want 0", tx_q.size() - tx0); end
    if (ifc.busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_in_resp got %b want 1", ifc.busy); end
    if (step_cnt - st0 != 1) begin failures++; $display("[TB] FAIL busy_step_pulse got %0d want 1", step_cnt - st0); end
    @(negedge clk);
    ifc.tx_busy = 1'b0;
    wait_tx(tx0 + 1, 20, cyc);
    repeat (5) @(negedge clk);
    #3;
    checks += 3;
    if (tx_q.size() != tx0 + 1 || tx_q[tx0] !== 8'h06) begin
      failures++; $display("[TB] FAIL busy_ack got n=%0d want one 06", tx_q.size() - tx0);
    end
    if (ifc.cpu_run !== 1'b0) begin failures++; $display("[TB] FAIL busy_dropped_r got cpu_run=%b want 0", ifc.cpu_run); end
    if (ifc.busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_idle got busy=%b want 0", ifc.busy); end
  endtask

  task automatic test_reset_midload;
    int we0, tx0, cyc;
    send_byte(8'h4C, 2);
    send_byte(8'h02, 2);
    send_byte(8'h78, 2);
    send_byte(8'h56, 1);
    #2;
    reset = 1'b0;
    #1;
    checks += 5;
    if (ifc.busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy got %b want 0", ifc.busy); end
    if (ifc.tx_data !== 8'h00) begin failures++; $display("[TB] FAIL rst_mid_tx_data got %h want 00", ifc.tx_data); end
    if (ifc.imem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_mid_wdata got %h want 0", ifc.imem_wdata); end
    if (ifc.imem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_we got %b want 0", ifc.imem_we); end
    if (ifc.cpu_run !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_cpu_run got %b want 0", ifc.cpu_run); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    we0 = we_addr_q.size();
    tx0 = tx_q.size();
    send_byte(8'h4C, 2);
    send_byte(8'h01, 2);
    send_byte(8'hAA, 2);
    send_byte(8'hBB, 2);
    send_byte(8'hCC, 2);
    send_byte(8'hDD, 0);
    wait_tx(tx0 + 1, 50, cyc);
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (we_addr_q.size() - we0 !== 1) begin
      failures++; $display("[TB] FAIL rst_reload_we_count got %0d want 1", we_addr_q.size() - we0);
    end else begin
      checks += 2;
      if (we_addr_q[we0] !== 8'h00) begin failures++; $display("[TB] FAIL rst_reload_addr got %h want 00", we_addr_q[we0]); end
      if (we_data_q[we0] !== 32'hDDCCBBAA) begin failures++; $display("[TB] FAIL rst_reload_wdata got %h want ddccbbaa", we_data_q[we0]); end
    end
    checks++;
    if (tx_q.size() != tx0 + 1 || tx_q[tx0] !== 8'h06) begin
      failures++; $display("[TB] FAIL rst_reload_ack got n=%0d want one 06", tx_q.size() - tx0);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    step_cnt     = 0;
    reset        = 1'b0;
    ifc.rx_data  = 8'h00;
    ifc.rx_valid = 1'b0;
    ifc.tx_busy  = 1'b0;
    test_reset();
    test_single_word();
    test_full_load();
    test_run_cmds();
    test_timeout();
    test_tx_busy();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_loader_ctrl.md
UART_LOADER_CTRL -- requirements
Module: uart_loader_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory word-address width (>= 8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning clocks without an rx byte before a load aborts.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_data  input  8  byte from the UART receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle pulse; rx_data is valid in that cycle.
REQ-007 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-008 SHALL have port tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
REQ-009 SHALL have port tx_data  output  8  response byte.
REQ-010 SHALL have port imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-011 SHALL have port imem_addr  output  ADDR_W  word address.
REQ-012 SHALL have port imem_wdata  output  32  word to write.
REQ-013 SHALL have port cpu_run  output  1  CPU free-run enable (level).
REQ-014 SHALL have port cpu_step  output  1  one-cycle single-step pulse.
REQ-015 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-016 SHALL implement states IDLE, LD_COUNT, LD_BYTE, LD_WRITE, RESP.
REQ-017 IDLE, rx_valid with 0x4C 'L' and cpu_run=0: SHALL go to LD_COUNT; word index and byte index cleared.
REQ-018 LD_COUNT, rx_valid: SHALL latch word count K = rx_data, with 0 meaning 256, then go to LD_BYTE.
REQ-019 LD_BYTE: each rx_valid SHALL place rx_data into the assembly register little-endian; the first byte goes to bits 7:0.
REQ-020 On the 4th byte of a word, the controller SHALL go to LD_WRITE; in the next cycle imem_we=1 for exactly one cycle, with imem_addr = word index (starting at 0) and imem_wdata = the assembled word.
REQ-021 After LD_WRITE, the controller SHALL return to LD_BYTE if words remain; otherwise it SHALL go to RESP with byte 0x06 (ACK).
REQ-022 IDLE, rx_valid with 0x52 'R': cpu_run SHALL set to 1 the next cycle; the controller SHALL queue ACK.
REQ-023 IDLE, rx_valid with 0x48 'H': cpu_run SHALL clear to 0 the next cycle; the controller SHALL queue ACK.
REQ-024 IDLE, rx_valid with 0x53 'S' and cpu_run=0: cpu_step SHALL be high for exactly one cycle (the next cycle); the controller SHALL queue ACK.
REQ-025 'L' or 'S' received while cpu_run=1, or any other byte in IDLE, SHALL queue 0x15 (NAK) and SHALL leave cpu_run unchanged.
REQ-026 RESP SHALL wait until tx_busy=0, then pulse tx_start for one cycle with tx_data held stable, and return to IDLE in the following cycle.
REQ-027 rx_valid arriving in RESP or LD_WRITE SHALL be dropped.
REQ-028 Timeout counter: SHALL clear on every rx_valid and on entry to LD_COUNT; SHALL count while in LD_COUNT or LD_BYTE.
REQ-029 When the timeout counter reaches TIMEOUT_CYCLES, the controller SHALL abort to RESP with NAK; words already written SHALL remain and no further imem_we SHALL occur.
REQ-030 The word index SHALL be 9 bits wide so it can count to 256; imem_addr SHALL be its low ADDR_W bits, zero-extended; the controller SHALL never write beyond word K-1.
REQ-031 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1).

Reset
REQ-032 reset=0 SHALL immediately force state IDLE and all outputs to 0: tx_start, tx_data, imem_we, imem_addr, imem_wdata, cpu_run, cpu_step, busy.
REQ-033 Reset SHALL clear all internal counters and the assembly register; a load interrupted by reset SHALL NOT resume.

Structure
REQ-034 Package uart_dbg_pkg SHALL hold the command bytes ('L', 'R', 'H', 'S'), ACK/NAK codes and the state encoding.
REQ-035 Byte-to-word packing (assembly register plus byte index) SHALL be the sub-module uart_word_assembler.

Verification
REQ-036 The bench SHALL drive 'L', 0x01, 0x78, 0x56, 0x34, 0x12 -> one imem_we with addr 0 and wdata 0x12345678, then tx_start with 0x06.
REQ-037 The bench SHALL drive 'L', 0x00, then 1024 bytes -> 256 writes at addr 0..255 and exactly one ACK.
REQ-038 The bench SHALL drive 'R', 'S', 'L', 'H' -> cpu_run rises, NAK, NAK, cpu_run falls, ACK; cpu_step and imem_we never asserted.
REQ-039 The bench SHALL drive 'L', 0x02, 5 bytes, then idle for TIMEOUT_CYCLES -> one write at addr 0, then NAK, then IDLE.
REQ-040 The bench SHALL hold tx_busy=1 for 50 cycles after 'S' -> tx_start issued only after tx_busy falls, and a byte received meanwhile is ignored.
REQ-041 The bench SHALL assert reset mid-word during a load -> all outputs 0 at once; a later 'L' load starts at addr 0.
